s4ga_cfg_streamer: RTL and testbench

//  Sequencer that feeds the serial LUT fabric. It fetches LUT config frames from byte-wide memory

---
 rtl/s4ga_cfg_streamer.sv | 161 ++++++++++++++++
 tb/tb_s4ga_cfg_streamer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/s4ga_cfg_streamer.sv
// Config streamer for the serial LUT fabric: prefetches frame bytes into a 4-deep FIFO,
// emits one 4-bit segment per enabled fabric clock and sequences the fabric reset.
//
// state  | meaning
// IDLE   | fabric clock gated, no requests; waits for run
// FRST   | fabric held in reset for RST_CYC enabled cycles while the FIFO prefills
// STREAM | segments stream; fab_ce follows FIFO non-empty
// DRAIN  | pass ended with run low; absorbs responses still in flight, then IDLE
module s4ga_cfg_streamer #(
    parameter int N = 71,
    parameter int K = 5,
    parameter int SI_W = 4,
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE = '0,
    parameter int RST_CYC = N + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [7:0]            mem_rdata,
    output logic                  fab_ce,
    output logic                  fab_rst,
    output logic [SI_W-1:0]       fab_si,
    output logic [$clog2(N)-1:0]  frame_n,
    output logic                  pass_done
);
    localparam int N_W = $clog2(N);
    localparam int IDX_SEGS = (N_W + 3) / 4;
    localparam int MASK_SEGS = ((1 << K) + 3) / 4;
    localparam int FSEGS = K * IDX_SEGS + MASK_SEGS;
    localparam int FBYTES = FSEGS / 2;
    localparam int SEG_W = $clog2(FSEGS);
    localparam int RC_W = $clog2(RST_CYC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE + ADDR_W'(N * FBYTES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FRST   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    generate
        if (FSEGS % 2 != 0) begin : g_bad_fsegs
            $error("s4ga_cfg_streamer: FSEGS must be even");
        end
        if (SI_W != 4) begin : g_bad_si_w
            $error("s4ga_cfg_streamer: SI_W must be 4");
        end
        if (RST_CYC <= N) begin : g_bad_rst_cyc
            $error("s4ga_cfg_streamer: RST_CYC must exceed N");
        end
    endgenerate

    logic [1:0]       state;
    logic [7:0]       fifo [4];
    logic [1:0]       head, tail;
    logic [2:0]       occ, outs, outs_nxt;
    logic             nib_lo;
    logic [SEG_W-1:0] seg_cnt;
    logic [RC_W-1:0]  rst_cnt;
    logic             active, consume, seg_last, frame_last;
    logic             gnt_take, ret, push, pop, flush;

    always_comb begin
        active     = (state == S_FRST) || (state == S_STREAM);
        consume    = (state == S_STREAM) && (occ != 3'd0);
        seg_last   = (seg_cnt == SEG_W'(FSEGS - 1));
        frame_last = (frame_n == N_W'(N - 1));
        mem_req    = active && (({1'b0, occ} + {1'b0, outs}) < 4'd4);
        gnt_take   = mem_req && mem_gnt;
        // responses with no outstanding credit belong to an abandoned request
        ret        = mem_rvalid && (outs != 3'd0);
        pass_done  = consume && seg_last && frame_last;
        flush      = pass_done && !run;
        push       = ret && active && !flush;
        pop        = consume && nib_lo;
        outs_nxt   = outs + 3'(gnt_take) - 3'(ret);
        fab_ce     = (state == S_FRST) || consume;
        fab_rst    = (state != S_STREAM);
        fab_si     = '0;
        if (consume) begin
            fab_si = nib_lo ? fifo[head][3:0] : fifo[head][7:4];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[tail] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mem_addr <= BASE;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            outs     <= '0;
            nib_lo   <= 1'b0;
            seg_cnt  <= '0;
            frame_n  <= '0;
            rst_cnt  <= '0;
        end else begin
            outs <= outs_nxt;
            if (gnt_take) begin
                mem_addr <= (mem_addr == LAST_ADDR) ? BASE : mem_addr + ADDR_W'(1);
            end
            if (flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                head <= head + 2'(pop);
                tail <= tail + 2'(push);
                occ  <= occ + 3'(push) - 3'(pop);
            end
            if (consume) begin
                nib_lo <= ~nib_lo;
                if (seg_last) begin
                    seg_cnt <= '0;
                    frame_n <= frame_last ? '0 : frame_n + N_W'(1);
                end else begin
                    seg_cnt <= seg_cnt + SEG_W'(1);
                end
            end
            case (state)
                S_IDLE: begin
                    mem_addr <= BASE;
                    if (run) begin
                        state   <= S_FRST;
                        rst_cnt <= RC_W'(RST_CYC - 1);
                        seg_cnt <= '0;
                        frame_n <= '0;
                        nib_lo  <= 1'b0;
                    end
                end
                S_FRST: begin
                    if (rst_cnt == '0) begin
                        state <= S_STREAM;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                S_STREAM: begin
                    if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                default: begin
                    if (outs_nxt == 3'd0) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// Bench for s4ga_cfg_streamer: random memory image and grant pattern, checked against
// a nibble-stream model of the image plus request-address and credit bookkeeping.
module tb_s4ga_cfg_streamer;
    localparam int NB   = 639;
    localparam int NS   = 2 * NB;
    localparam int FSG  = 18;
    localparam int RSTC = 72;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        fab_ce, fab_rst;
    logic [3:0]  fab_si;
    logic [6:0]  frame_n;
    logic        pass_done;

    s4ga_cfg_streamer dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fab_ce(fab_ce), .fab_rst(fab_rst), .fab_si(fab_si),
        .frame_n(frame_n), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int ready;
    } rq_t;

    logic [7:0] img [NB];
    rq_t q[$];
    int  total = 0, bad = 0;
    int  cyc = 0, gnt_pct = 100, lat = 1;
    bit  chk_en = 1'b0, rst_seen = 1'b0;
    int  pos = 0, exp_req = 0, rst_run = 0, gap_cnt = 0, pd_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // memory responder and stream monitor share one negedge process so their order is fixed
    initial begin
        rq_t        r;
        logic [7:0] b;
        logic       pd_exp;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
            if (q.size() > 0 && q[0].ready <= cyc) begin
                r = q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = (r.addr < NB) ? img[r.addr] : 8'h00;
            end
            mem_gnt = mem_req && ($urandom_range(0, 99) < gnt_pct);
            if (mem_gnt) q.push_back('{int'(mem_addr), cyc + lat});
            if (chk_en) begin
                if (mem_gnt) begin
                    check("req_addr", 32'(mem_addr), 32'(exp_req % NB));
                    check("credit", 32'((exp_req - pos / 2) < 4), 32'd1);
                    exp_req++;
                end
                pd_exp = fab_ce && !fab_rst && (pos % NS == NS - 1);
                check("pass_done", 32'(pass_done), 32'(pd_exp));
                if (pass_done) pd_cnt++;
                if (fab_ce && fab_rst) rst_run++;
                if (fab_ce && !fab_rst) begin
                    if (!rst_seen) begin
                        check("rst_len", 32'(rst_run), 32'(RSTC));
                        rst_seen = 1'b1;
                    end
                    b = img[(pos / 2) % NB];
                    check("fab_si", 32'(fab_si), (pos % 2 == 0) ? 32'(b[7:4]) : 32'(b[3:0]));
                    check("frame_n", 32'(frame_n), 32'((pos % NS) / FSG));
                    pos++;
                end
                if (!fab_ce && rst_seen) gap_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        pos = 0; exp_req = 0; rst_run = 0; gap_cnt = 0; pd_cnt = 0;
        rst_seen = 1'b0;
        chk_en = 1'b1;
        run = 1'b1;
    endtask

    task automatic wait_pos(input int target, input int limit, input string tag);
        int n = 0;
        while (pos < target && n < limit) begin
            step();
            n++;
        end
        check({tag, "_reached"}, 32'(pos >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_fab_ce"}, 32'(fab_ce), 32'd0);
        check({tag, "_fab_rst"}, 32'(fab_rst), 32'd1);
        check({tag, "_fab_si"}, 32'(fab_si), 32'd0);
        check({tag, "_frame_n"}, 32'(frame_n), 32'd0);
        check({tag, "_pass_done"}, 32'(pass_done), 32'd0);
    endtask

    initial begin
        int n, busy;
        for (int i = 0; i < NB; i++) img[i] = 8'($urandom);

        // reset state
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // first pass at latency 1, full grant: no gaps once streaming
        start_run();
        wait_pos(NS, 4000, "pass1");
        check("pass1_gaps", 32'(gap_cnt), 32'd0);
        check("pass1_pd", 32'(pd_cnt), 32'd1);

        // second pass with sparse grants and long latency: underflow must stall, not corrupt
        gnt_pct = 30; lat = 5; gap_cnt = 0;
        wait_pos(2 * NS, 12000, "pass2");
        check("pass2_underflow_seen", 32'(gap_cnt > 0), 32'd1);
        check("pass2_pd", 32'(pd_cnt), 32'd2);

        // drop run in frame 40 of the third pass
        gnt_pct = 100; lat = 3;
        n = 0;
        while (!(frame_n == 7'd40 && pos >= 2 * NS) && n < 4000) begin step(); n++; end
        check("frame40_reached", 32'(n < 4000), 32'd1);
        run = 1'b0;
        n = 0;
        while (pd_cnt < 3 && n < 4000) begin step(); n++; end
        check("pass3_done", 32'(pd_cnt), 32'd3);
        check("pass3_len", 32'(pos), 32'(3 * NS));
        busy = 0;
        repeat (40) begin
            if (fab_ce || mem_req) busy++;
            step();
        end
        check("idle_quiet", 32'(busy), 32'd0);
        check("idle_frame_n", 32'(frame_n), 32'd0);

        // re-entry from IDLE: fresh fabric reset and restart at frame 0
        lat = 1;
        start_run();
        wait_pos(300, 2000, "reentry");
        check("reentry_pd", 32'(pd_cnt), 32'd0);

        // synchronous reset with several requests in flight
        lat = 5;
        n = 0;
        while (q.size() < 3 && n < 2000) begin step(); n++; end
        check("outstanding3", 32'(q.size() >= 3), 32'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        run = 1'b0;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        busy = 0;
        repeat (30) begin
            step();
            if (fab_ce || fab_si != 4'd0 || mem_req) busy++;
        end
        check("late_rvalid_ignored", 32'(busy), 32'd0);
        lat = 1;
        start_run();
        wait_pos(200, 2000, "after_rst");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
